// File: rtl/set_bit_arbiter_if.sv
// Producer-side request/beat bundle and set_bit-side outputs of set_bit_arbiter.
// The producers drive the master modport; the arbiter takes the slave modport.
interface set_bit_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 32
);
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ-1:0]       in_enable;
    logic [NUM_REQ-1:0][63:0] in_val;
    logic [NUM_REQ-1:0][63:0] in_size_of_bit;
    logic [NUM_REQ-1:0]       in_flush;
    logic [NUM_REQ-1:0]       in_last;

    logic [NUM_REQ-1:0]       gnt;
    logic                     busy;
    logic [2:0]               owner;
    logic                     sb_enable;
    logic [63:0]              sb_val;
    logic [63:0]              sb_size_of_bit;
    logic                     sb_flush;
    logic [CNT_W-1:0]         total_bits;
    logic [CNT_W-1:0]         total_bytes;
    logic                     protocol_error;

    modport master (
        output req, in_enable, in_val, in_size_of_bit, in_flush, in_last,
        input  gnt, busy, owner, sb_enable, sb_val, sb_size_of_bit, sb_flush,
               total_bits, total_bytes, protocol_error
    );

    modport slave (
        input  req, in_enable, in_val, in_size_of_bit, in_flush, in_last,
        output gnt, busy, owner, sb_enable, sb_val, sb_size_of_bit, sb_flush,
               total_bits, total_bytes, protocol_error
    );
endinterface

// File: rtl/set_bit_arbiter.sv
// Burst arbiter in front of the shared set_bit writer: grants one producer per burst,
// forwards its beats registered and counts forwarded bits. SET_BIT_ARB_RR_EN selects round-robin.
module set_bit_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    set_bit_arbiter_if.slave bus
);
    typedef enum logic {IDLE, BUSY} state_e;

    state_e             state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [2:0]         owner_q, owner_d;
    logic               sb_enable_q, sb_enable_d;
    logic [63:0]        sb_val_q, sb_val_d;
    logic [63:0]        sb_size_of_bit_q, sb_size_of_bit_d;
    logic               sb_flush_q, sb_flush_d;
    logic [CNT_W-1:0]   total_bits_q, total_bits_d;
    logic               protocol_error_q, protocol_error_d;

    logic               win_found;
    logic [2:0]         win_idx;
`ifdef SET_BIT_ARB_RR_EN
    logic [2:0]         rr_ptr_q, rr_ptr_d;
`endif

    logic               own_req, own_en, own_flush, own_last;
    logic [63:0]        own_val, own_size;
    logic [CNT_W-1:0]   bits_sum, bits_round;

    // Two-pass search: first indices at or above the pointer, then wrap to the lowest.
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin : arbitrate
        win_found = 1'b0;
        win_idx   = '0;
`ifdef SET_BIT_ARB_RR_EN
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!win_found && bus.req[k] && (3'(k) >= rr_ptr_q)) begin
                win_found = 1'b1;
                win_idx   = 3'(k);
            end
        end
`endif
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!win_found && bus.req[k]) begin
                win_found = 1'b1;
                win_idx   = 3'(k);
            end
        end
    end

    always_comb begin : owner_mux
        own_req   = 1'b0;
        own_en    = 1'b0;
        own_val   = '0;
        own_size  = '0;
        own_flush = 1'b0;
        own_last  = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (owner_q == 3'(k)) begin
                own_req   = bus.req[k];
                own_en    = bus.in_enable[k];
                own_val   = bus.in_val[k];
                own_size  = bus.in_size_of_bit[k];
                own_flush = bus.in_flush[k];
                own_last  = bus.in_last[k];
            end
        end
    end

    // A flush pads the running count up to the next byte boundary; both wrap.
    assign bits_sum   = total_bits_q + CNT_W'(own_size);
    assign bits_round = (bits_sum + CNT_W'(7)) & ~CNT_W'(7);

    always_comb begin : next_state
        state_d          = state_q;
        gnt_d            = gnt_q;
        owner_d          = owner_q;
        sb_enable_d      = 1'b0;
        sb_val_d         = '0;
        sb_size_of_bit_d = '0;
        sb_flush_d       = 1'b0;
        total_bits_d     = total_bits_q;
        protocol_error_d = protocol_error_q;
`ifdef SET_BIT_ARB_RR_EN
        rr_ptr_d         = rr_ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (|bus.in_enable) protocol_error_d = 1'b1;
                if (win_found) begin
                    state_d = BUSY;
                    gnt_d   = NUM_REQ'(1) << win_idx;
                    owner_d = win_idx;
`ifdef SET_BIT_ARB_RR_EN
                    rr_ptr_d = (win_idx == 3'(NUM_REQ - 1)) ? 3'd0 : win_idx + 3'd1;
`endif
                end
            end
            BUSY: begin
                if (|(bus.in_enable & ~gnt_q)) protocol_error_d = 1'b1;
                if (own_en) begin
                    if (own_size > 64'd64) begin
                        protocol_error_d = 1'b1;
                    end else begin
                        sb_enable_d      = 1'b1;
                        sb_val_d         = own_val;
                        sb_size_of_bit_d = own_size;
                        sb_flush_d       = own_flush;
                        total_bits_d     = own_flush ? bits_round : bits_sum;
                    end
                end
                // Last beat or a dropped request both end the burst; the drop is an abort.
                if ((own_en && own_last) || !own_req) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    owner_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= IDLE;
            gnt_q            <= '0;
            owner_q          <= '0;
            sb_enable_q      <= 1'b0;
            sb_val_q         <= '0;
            sb_size_of_bit_q <= '0;
            sb_flush_q       <= 1'b0;
            total_bits_q     <= '0;
            protocol_error_q <= 1'b0;
`ifdef SET_BIT_ARB_RR_EN
            rr_ptr_q         <= '0;
`endif
        end else begin
            state_q          <= state_d;
            gnt_q            <= gnt_d;
            owner_q          <= owner_d;
            sb_enable_q      <= sb_enable_d;
            sb_val_q         <= sb_val_d;
            sb_size_of_bit_q <= sb_size_of_bit_d;
            sb_flush_q       <= sb_flush_d;
            total_bits_q     <= total_bits_d;
            protocol_error_q <= protocol_error_d;
`ifdef SET_BIT_ARB_RR_EN
            rr_ptr_q         <= rr_ptr_d;
`endif
        end
    end

    assign bus.gnt            = gnt_q;
    assign bus.busy           = (state_q == BUSY);
    assign bus.owner          = owner_q;
    assign bus.sb_enable      = sb_enable_q;
    assign bus.sb_val         = sb_val_q;
    assign bus.sb_size_of_bit = sb_size_of_bit_q;
    assign bus.sb_flush       = sb_flush_q;
    assign bus.total_bits     = total_bits_q;
    assign bus.total_bytes    = CNT_W'(({1'b0, total_bits_q} + (CNT_W + 1)'(7)) >> 3);
    assign bus.protocol_error = protocol_error_q;
endmodule

// File: tb/tb_set_bit_arbiter.sv
// Directed bench for set_bit_arbiter: cycle tables with hand-computed expectations,
// plus hand-written sequences for arbitration order and mid-burst reset.
module tb_set_bit_arbiter;
    localparam int NUM_REQ = 4;
    localparam int CNT_W   = 32;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    set_bit_arbiter_if #(.NUM_REQ(NUM_REQ), .CNT_W(CNT_W)) bus ();
    set_bit_arbiter #(.NUM_REQ(NUM_REQ), .CNT_W(CNT_W)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        string       name;
        logic [3:0]  req;
        logic [3:0]  en;
        int          src;
        logic [63:0] val;
        logic [63:0] size;
        logic        flush;
        logic        last;
        logic [3:0]  e_gnt;
        logic        e_busy;
        logic [2:0]  e_owner;
        logic        e_sb_en;
        logic [63:0] e_val;
        logic [63:0] e_size;
        logic        e_flush;
        logic [31:0] e_bits;
        logic [31:0] e_bytes;
        logic        e_perr;
    } vec_t;

    int n_checks = 0;
    int n_errors = 0;

    // Expected owner of each one-beat burst with req=0101 held; the earlier grant
    // to requester 1 leaves the round-robin pointer at 2.
`ifdef SET_BIT_ARB_RR_EN
    int exp_own[4] = '{2, 0, 2, 0};
`else
    int exp_own[4] = '{0, 0, 0, 0};
`endif

    vec_t tbl_a[3];
    vec_t tbl_b[9];
    vec_t tbl_c[3];

    task automatic check(input string what, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", what, act, exp);
        end
    endtask

    // Non-source requesters carry distinctive data so a wrong mux shows up.
    task automatic drive(input logic [3:0] req, input logic [3:0] en, input int src,
                         input logic [63:0] val, input logic [63:0] size,
                         input logic flush, input logic last);
        bus.req       = req;
        bus.in_enable = en;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (i == src) begin
                bus.in_val[i]         = val;
                bus.in_size_of_bit[i] = size;
                bus.in_flush[i]       = flush;
                bus.in_last[i]        = last;
            end else begin
                bus.in_val[i]         = 64'hDEAD_0000_0000_0000 | 64'(i);
                bus.in_size_of_bit[i] = 64'd7;
                bus.in_flush[i]       = 1'b1;
                bus.in_last[i]        = 1'b1;
            end
        end
    endtask

    task automatic apply_vec(input vec_t v);
        @(negedge clock);
        drive(v.req, v.en, v.src, v.val, v.size, v.flush, v.last);
        @(posedge clock);
        #1;
        check({v.name, ".gnt"},      64'(bus.gnt),            64'(v.e_gnt));
        check({v.name, ".busy"},     64'(bus.busy),           64'(v.e_busy));
        check({v.name, ".owner"},    64'(bus.owner),          64'(v.e_owner));
        check({v.name, ".sb_en"},    64'(bus.sb_enable),      64'(v.e_sb_en));
        check({v.name, ".sb_val"},   bus.sb_val,              v.e_val);
        check({v.name, ".sb_size"},  bus.sb_size_of_bit,      v.e_size);
        check({v.name, ".sb_flush"}, 64'(bus.sb_flush),       64'(v.e_flush));
        check({v.name, ".bits"},     64'(bus.total_bits),     64'(v.e_bits));
        check({v.name, ".bytes"},    64'(bus.total_bytes),    64'(v.e_bytes));
        check({v.name, ".perr"},     64'(bus.protocol_error), 64'(v.e_perr));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".gnt"},   64'(bus.gnt),            64'd0);
        check({tag, ".busy"},  64'(bus.busy),           64'd0);
        check({tag, ".owner"}, 64'(bus.owner),          64'd0);
        check({tag, ".sb_en"}, 64'(bus.sb_enable),      64'd0);
        check({tag, ".sb_val"}, bus.sb_val,             64'd0);
        check({tag, ".sb_size"}, bus.sb_size_of_bit,    64'd0);
        check({tag, ".sb_flush"}, 64'(bus.sb_flush),    64'd0);
        check({tag, ".bits"},  64'(bus.total_bits),     64'd0);
        check({tag, ".bytes"}, 64'(bus.total_bytes),    64'd0);
        check({tag, ".perr"},  64'(bus.protocol_error), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Fields: name, req, en, src, val, size, flush, last |
        //         gnt, busy, owner, sb_en, sb_val, sb_size, sb_flush, bits, bytes, perr
        tbl_a[0] = '{"a0_grant", 4'b0010, 4'b0000, 1, 64'h0, 64'd0, 1'b0, 1'b0,
                     4'b0010, 1'b1, 3'd1, 1'b0, 64'h0, 64'd0, 1'b0, 32'd0, 32'd0, 1'b0};
        tbl_a[1] = '{"a1_last", 4'b0010, 4'b0010, 1, 64'h5, 64'd3, 1'b0, 1'b1,
                     4'b0000, 1'b0, 3'd0, 1'b1, 64'h5, 64'd3, 1'b0, 32'd3, 32'd1, 1'b0};
        tbl_a[2] = '{"a2_idle", 4'b0000, 4'b0000, 0, 64'h0, 64'd0, 1'b0, 1'b0,
                     4'b0000, 1'b0, 3'd0, 1'b0, 64'h0, 64'd0, 1'b0, 32'd3, 32'd1, 1'b0};

        tbl_b[0] = '{"b0_grant0", 4'b0001, 4'b0000, 0, 64'h0, 64'd0, 1'b0, 1'b0,
                     4'b0001, 1'b1, 3'd0, 1'b0, 64'h0, 64'd0, 1'b0, 32'd35, 32'd5, 1'b0};
        tbl_b[1] = '{"b1_intruder", 4'b0101, 4'b0101, 0, 64'hAB, 64'd8, 1'b0, 1'b0,
                     4'b0001, 1'b1, 3'd0, 1'b1, 64'hAB, 64'd8, 1'b0, 32'd43, 32'd6, 1'b1};
        tbl_b[2] = '{"b2_size65", 4'b0001, 4'b0001, 0, 64'h1FF, 64'd65, 1'b0, 1'b0,
                     4'b0001, 1'b1, 3'd0, 1'b0, 64'h0, 64'd0, 1'b0, 32'd43, 32'd6, 1'b1};
        tbl_b[3] = '{"b3_beat2", 4'b0001, 4'b0001, 0, 64'h3, 64'd2, 1'b0, 1'b0,
                     4'b0001, 1'b1, 3'd0, 1'b1, 64'h3, 64'd2, 1'b0, 32'd45, 32'd6, 1'b1};
        tbl_b[4] = '{"b4_pureflush", 4'b0001, 4'b0001, 0, 64'h0, 64'd0, 1'b1, 1'b0,
                     4'b0001, 1'b1, 3'd0, 1'b1, 64'h0, 64'd0, 1'b1, 32'd48, 32'd6, 1'b1};
        tbl_b[5] = '{"b5_last64", 4'b0011, 4'b0001, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd64, 1'b0, 1'b1,
                     4'b0000, 1'b0, 3'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd64, 1'b0, 32'd112, 32'd14, 1'b1};
        tbl_b[6] = '{"b6_newreq", 4'b0010, 4'b0000, 1, 64'h0, 64'd0, 1'b0, 1'b0,
                     4'b0010, 1'b1, 3'd1, 1'b0, 64'h0, 64'd0, 1'b0, 32'd112, 32'd14, 1'b1};
        tbl_b[7] = '{"b7_abort", 4'b0000, 4'b0000, 1, 64'h0, 64'd0, 1'b0, 1'b0,
                     4'b0000, 1'b0, 3'd0, 1'b0, 64'h0, 64'd0, 1'b0, 32'd112, 32'd14, 1'b1};
        tbl_b[8] = '{"b8_idle_en", 4'b0000, 4'b0010, 1, 64'h77, 64'd5, 1'b0, 1'b0,
                     4'b0000, 1'b0, 3'd0, 1'b0, 64'h0, 64'd0, 1'b0, 32'd112, 32'd14, 1'b1};

        tbl_c[0] = '{"c0_flush13", 4'b0100, 4'b0100, 2, 64'h1ABC, 64'd13, 1'b1, 1'b0,
                     4'b0100, 1'b1, 3'd2, 1'b1, 64'h1ABC, 64'd13, 1'b1, 32'd16, 32'd2, 1'b0};
        tbl_c[1] = '{"c1_size65", 4'b0100, 4'b0100, 2, 64'h5, 64'd65, 1'b0, 1'b0,
                     4'b0100, 1'b1, 3'd2, 1'b0, 64'h0, 64'd0, 1'b0, 32'd16, 32'd2, 1'b1};
        tbl_c[2] = '{"c2_abort", 4'b0000, 4'b0000, 2, 64'h0, 64'd0, 1'b0, 1'b0,
                     4'b0000, 1'b0, 3'd0, 1'b0, 64'h0, 64'd0, 1'b0, 32'd16, 32'd2, 1'b1};

        drive(4'b0000, 4'b0000, 0, 64'h0, 64'd0, 1'b0, 1'b0);
        repeat (2) @(posedge clock);
        #1;
        check_all_zero("reset");
        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < 3; i++) apply_vec(tbl_a[i]);

        // Arbitration order with req=0101 held and one-beat bursts.
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            drive(4'b0101, 4'b0000, 0, 64'h0, 64'd0, 1'b0, 1'b0);
            @(posedge clock);
            #1;
            check($sformatf("arb%0d.gnt", k), 64'(bus.gnt), 64'(4'b0001 << exp_own[k]));
            check($sformatf("arb%0d.owner", k), 64'(bus.owner), 64'(exp_own[k]));
            @(negedge clock);
            drive(4'b0101, 4'b0001 << exp_own[k], exp_own[k], 64'h10 + 64'(k), 64'd8, 1'b0, 1'b1);
            @(posedge clock);
            #1;
            check($sformatf("arb%0d.sb_val", k), bus.sb_val, 64'h10 + 64'(k));
            check($sformatf("arb%0d.gnt_drop", k), 64'(bus.gnt), 64'd0);
            check($sformatf("arb%0d.bits", k), 64'(bus.total_bits), 64'(3 + 8 * (k + 1)));
        end
        @(negedge clock);
        drive(4'b0000, 4'b0000, 0, 64'h0, 64'd0, 1'b0, 1'b0);
        @(posedge clock);
        #1;
        check("arb_end.gnt", 64'(bus.gnt), 64'd0);

        for (int i = 0; i < 9; i++) apply_vec(tbl_b[i]);

        // Mid-burst reset after two beats; a held req is re-arbitrated from IDLE.
        @(negedge clock);
        drive(4'b0100, 4'b0000, 2, 64'h0, 64'd0, 1'b0, 1'b0);
        @(posedge clock);
        #1;
        check("rst_seq.gnt", 64'(bus.gnt), 64'(4'b0100));
        for (int j = 0; j < 2; j++) begin
            @(negedge clock);
            drive(4'b0100, 4'b0100, 2, 64'(j + 1), 64'd4, 1'b0, 1'b0);
            @(posedge clock);
            #1;
            check($sformatf("rst_seq.beat%0d", j), 64'(bus.total_bits), 64'(112 + 4 * (j + 1)));
        end
        @(negedge clock);
        drive(4'b0100, 4'b0100, 2, 64'h9, 64'd4, 1'b0, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("rst_async");
        @(posedge clock);
        #1;
        check("rst_hold.sb_en", 64'(bus.sb_enable), 64'd0);
        check("rst_hold.gnt", 64'(bus.gnt), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        drive(4'b0100, 4'b0000, 2, 64'h0, 64'd0, 1'b0, 1'b0);
        #1;
        check("rst_release.gnt", 64'(bus.gnt), 64'd0);
        @(posedge clock);
        #1;
        check("rst_rearb.gnt", 64'(bus.gnt), 64'(4'b0100));
        check("rst_rearb.busy", 64'(bus.busy), 64'd1);

        for (int i = 0; i < 3; i++) apply_vec(tbl_c[i]);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
